xdff_scan_unload: RTL and testbench

//  Reader side of the xDFF storage bank: snapshots a WIDTH-bit parallel word held in

---
 rtl/xdff_scan_unload.sv | 119 +++++++++++
 tb/tb_xdff_scan_unload.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/xdff_scan_unload.sv
// ---------------------------------------------------------------------------
// xdff_scan_unload
//
// This is the reader side of the xDFF storage bank. It takes a snapshot of a
// WIDTH-bit parallel word and shifts it out serially over a valid/ready link,
// sending one bit per accepted beat. It reports busy and done status to the
// controlling FSM.
//
// Handshake: a beat occurs on a rising clk0 edge when ser_valid & ser_ready.
// While ser_valid is high and ser_ready is low, ser_out and ser_valid hold
// steady. The block never drops ser_valid before the bit has been accepted.
// ser_out is 0 whenever ser_valid is 0.
//
// Ports
//   clk0        in   1      single clock, rising edge
//   Rs          in   1      synchronous reset, active-high, top priority
//   start       in   1      unload request, sampled only in IDLE
//   par_in      in   WIDTH  parallel word, captured on an accepted start
//   ser_out     out  1      current serial bit
//   ser_valid   out  1      ser_out holds a valid bit
//   ser_ready   in   1      sink accepts the bit when ser_valid & ser_ready
//   busy        out  1      high while bits are being unloaded (SHIFT)
//   done        out  1      one-cycle pulse after the last accepted beat
//   dbg_state_o out  2      current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module xdff_scan_unload #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk0,
    input  logic             Rs,
    input  logic             start,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shifted;

    // Move the register one place toward the output end and fill with 0.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk0) begin
        if (Rs) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = par_in;
                    count_d = CW'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_out   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
                // ser_valid is always high here, so a beat is just ser_ready.
                if (ser_ready) begin
                    shift_d = shifted;
                    count_d = count_q - CW'(1);
                    // Leaving at count 1 keeps the counter from wrapping.
                    if (count_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_xdff_scan_unload.sv
module tb_xdff_scan_unload;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    int checks = 0;
    int errors = 0;

    // DUT A: WIDTH=8, MSB first
    logic       rs_a, start_a, rdy_a;
    logic [7:0] par_a;
    logic       so_a, sv_a, busy_a, done_a;
    logic [1:0] st_a;

    // DUT B: WIDTH=8, LSB first
    logic       rs_b, start_b, rdy_b;
    logic [7:0] par_b;
    logic       so_b, sv_b, busy_b, done_b;
    logic [1:0] st_b;

    // DUT C: WIDTH=2, MSB first
    logic       rs_c, start_c, rdy_c;
    logic [1:0] par_c;
    logic       so_c, sv_c, busy_c, done_c;
    logic [1:0] st_c;

    xdff_scan_unload #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
        .clk0(clk0), .Rs(rs_a), .start(start_a), .par_in(par_a),
        .ser_out(so_a), .ser_valid(sv_a), .ser_ready(rdy_a),
        .busy(busy_a), .done(done_a), .dbg_state_o(st_a)
    );

    xdff_scan_unload #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
        .clk0(clk0), .Rs(rs_b), .start(start_b), .par_in(par_b),
        .ser_out(so_b), .ser_valid(sv_b), .ser_ready(rdy_b),
        .busy(busy_b), .done(done_b), .dbg_state_o(st_b)
    );

    xdff_scan_unload #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (
        .clk0(clk0), .Rs(rs_c), .start(start_c), .par_in(par_c),
        .ser_out(so_c), .ser_valid(sv_c), .ser_ready(rdy_c),
        .busy(busy_c), .done(done_c), .dbg_state_o(st_c)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full unload on DUT A with ready held high, checking every beat and the
    // done pulse. par_a is changed right after capture to show it is ignored.
    task automatic run_a(input string tag, input logic [7:0] word);
        par_a   = word;
        start_a = 1'b1;
        rdy_a   = 1'b1;
        tick();
        start_a = 1'b0;
        par_a   = ~word;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_vbd"}, {sv_a, busy_a, done_a}, 3'b110);
            chk({tag, "_bit"}, so_a, word[7-i]);
            par_a = par_a + 8'd1;
            tick();
        end
        chk({tag, "_done"}, {done_a, busy_a, sv_a, so_a}, 4'b1000);
        chk({tag, "_done_st"}, st_a, 2'd2);
        tick();
        chk({tag, "_idle"}, {done_a, busy_a, sv_a, so_a}, 4'b0000);
        chk({tag, "_idle_st"}, st_a, 2'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic [1:0] wc;
        int beats;
        int c;
        logic [3:0] rpat;

        rs_a = 1'b1; start_a = 1'b0; rdy_a = 1'b0; par_a = '0;
        rs_b = 1'b1; start_b = 1'b0; rdy_b = 1'b0; par_b = '0;
        rs_c = 1'b1; start_c = 1'b0; rdy_c = 1'b0; par_c = '0;
        tick();
        tick();
        rs_a = 1'b0; rs_b = 1'b0; rs_c = 1'b0;

        // Reset state of all three instances
        chk("rst_a", {so_a, sv_a, busy_a, done_a, st_a}, 6'b0);
        chk("rst_b", {so_b, sv_b, busy_b, done_b, st_b}, 6'b0);
        chk("rst_c", {so_c, sv_c, busy_c, done_c, st_c}, 6'b0);

        // Idle with start low stays idle
        tick();
        chk("idle_hold", {so_a, sv_a, busy_a, done_a, st_a}, 6'b0);

        // A5 MSB first: 1,0,1,0,0,1,0,1
        run_a("a5", 8'hA5);

        // Reset for two cycles after three beats of an unload
        par_a = 8'h3C; start_a = 1'b1; rdy_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(); tick(); tick();
        chk("mid_shift_st", st_a, 2'd1);
        chk("mid_shift_bit", so_a, 1'b1);    // 3C = 0011_1100, 4th bit sent is 1
        rs_a = 1'b1;
        tick();
        chk("rst1_out", {so_a, sv_a, busy_a, done_a, st_a}, 6'b0);
        tick();
        rs_a = 1'b0;
        chk("rst2_out", {so_a, sv_a, busy_a, done_a, st_a}, 6'b0);
        tick();
        chk("rst_no_done1", {done_a, st_a}, 3'b0);
        tick();
        chk("rst_no_done2", {done_a, st_a}, 3'b0);
        run_a("post_rst", 8'h81);

        // F0 with ready pattern 1,0,0,1 repeating: stream 1,1,1,1,0,0,0,0
        w = 8'hF0;
        rpat = 4'b1001;        // rpat[3] used first
        par_a = w; start_a = 1'b1; rdy_a = 1'b1;
        tick();
        start_a = 1'b0;
        beats = 0;
        c = 0;
        while (beats < 8 && c < 40) begin
            rdy_a = rpat[3 - (c % 4)];
            chk("stall_vb", {sv_a, busy_a, done_a}, 3'b110);
            chk("stall_bit", so_a, w[7-beats]);
            if (rdy_a) beats++;
            c++;
            tick();
        end
        chk("stall_beats", beats, 8);
        chk("stall_done", {done_a, busy_a, sv_a, so_a}, 4'b1000);
        rdy_a = 1'b1;
        tick();
        chk("stall_idle", st_a, 2'd0);

        // start held high, par_in changing every cycle
        start_a = 1'b1; rdy_a = 1'b1; par_a = 8'h5A;
        tick();
        w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            par_a = 8'(i * 37 + 1);
            chk("b2b1_bit", {sv_a, so_a}, {1'b1, w[7-i]});
            tick();
        end
        par_a = 8'hFF;         // start is ignored in DONE
        chk("b2b1_done", {done_a, busy_a, sv_a, st_a}, 5'b10010);
        tick();
        par_a = 8'hC3;         // captured at the end of this IDLE cycle
        chk("b2b_idle", {done_a, busy_a, sv_a, st_a}, 5'b00000);
        tick();
        w = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            par_a = 8'(i * 53 + 7);
            chk("b2b2_bit", {sv_a, so_a}, {1'b1, w[7-i]});
            tick();
        end
        start_a = 1'b0;
        chk("b2b2_done", {done_a, busy_a, sv_a, st_a}, 5'b10010);
        tick();
        chk("b2b2_idle", st_a, 2'd0);
        tick();
        chk("b2b2_stay", st_a, 2'd0);

        // LSB first, 01: first bit 1, then seven 0s
        w = 8'h01;
        par_b = w; start_b = 1'b1; rdy_b = 1'b1;
        tick();
        start_b = 1'b0;
        par_b = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_bit", {sv_b, busy_b, so_b}, {2'b11, w[i]});
            tick();
        end
        chk("lsb_done", {done_b, busy_b, sv_b, so_b}, 4'b1000);
        tick();
        chk("lsb_idle", st_b, 2'd0);

        // WIDTH=2, 10: bits 1,0 then done, no extra beat
        wc = 2'b10;
        par_c = wc; start_c = 1'b1; rdy_c = 1'b1;
        tick();
        start_c = 1'b0;
        chk("w2_bit0", {sv_c, so_c}, {1'b1, wc[1]});
        tick();
        chk("w2_bit1", {sv_c, so_c}, {1'b1, wc[0]});
        tick();
        chk("w2_done", {done_c, busy_c, sv_c, so_c}, 4'b1000);
        tick();
        chk("w2_idle", {done_c, busy_c, sv_c, st_c}, 5'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
